// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - multiplexed 7-segment scan controller with PWM brightness
//
// Purpose: time-multiplexes NUM_DIGITS digits onto a shared segment bus. Each
// digit slot is BLANK (anti-ghosting gap), LIT (length set by brightness), then
// DARK. New patterns arrive through a valid/ready handshake into a pending
// buffer and are promoted to the displayed buffer only at a frame boundary.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   enable            scan enable; low forces dark outputs and restarts at digit 0
//   brightness        lit duty level, sampled during slot cycle 0
//   load_valid/ready  pattern handshake; ready means the pending buffer is free
//   load_digits       byte i = digit i, {a,b,c,d,e,f,g,dp}
//   seg, dp           segment outputs, active high
//   digit_sel         one-hot digit select, all zero when dark
//   frame_done        pulse in the last cycle of the last slot
module seg7_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 256,
  parameter int BLANK_CYCLES = 16,
  parameter int BR_W         = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [BR_W-1:0]         brightness,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [8*NUM_DIGITS-1:0] load_digits,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int STEP = (DIGIT_CYCLES - BLANK_CYCLES) / ((1 << BR_W) - 1);
  localparam int CW   = $clog2(DIGIT_CYCLES);
  localparam int IW   = $clog2(NUM_DIGITS);

  localparam logic [CW:0]   BLANK_W  = (CW+1)'(BLANK_CYCLES);
  localparam logic [CW:0]   STEP_W   = (CW+1)'(STEP);
  localparam logic [CW:0]   ONE_W    = (CW+1)'(1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DIGIT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  typedef enum logic [1:0] {IDLE, BLANK, LIT, DARK} state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [IW-1:0]           idx, idx_nx;
  logic [BR_W-1:0]         bright, bright_use;
  logic [CW:0]             cnt_p1, lit_end;

  logic [8*NUM_DIGITS-1:0] active, pend_buf;
  logic                    pending, xfer, swap;

  logic [6:0]              seg_nx;
  logic                    dp_nx;
  logic [NUM_DIGITS-1:0]   sel_nx;
  logic                    fd_nx;

  // State register; brightness is latched at the end of slot cycle 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      bright <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      if (state == BLANK && cnt == '0)
        bright <= brightness;
    end
  end

  // Next state. During slot cycle 0 the latch has not captured yet, so the
  // live input is used (matters only when BLANK_CYCLES is 1).
  always_comb begin
    bright_use = (state == BLANK && cnt == '0) ? brightness : bright;
    cnt_p1     = {1'b0, cnt} + ONE_W;
    lit_end    = BLANK_W + (CW+1)'(bright_use) * STEP_W;
    state_nx   = state;
    cnt_nx     = cnt;
    idx_nx     = idx;
    if (!enable) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else if (state == IDLE) begin
      state_nx = BLANK;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else if (cnt == LAST_CNT) begin
      state_nx = BLANK;
      cnt_nx   = '0;
      idx_nx   = (idx == LAST_IDX) ? '0 : idx + ONE_IDX;
    end else begin
      cnt_nx = cnt_p1[CW-1:0];
      // At full brightness lit_end equals DIGIT_CYCLES, so DARK never occurs.
      if (cnt_p1 < BLANK_W)
        state_nx = BLANK;
      else if (cnt_p1 < lit_end)
        state_nx = LIT;
      else
        state_nx = DARK;
    end
  end

  // Output decode from the next state, so registered outputs line up with it.
  always_comb begin
    seg_nx = '0;
    dp_nx  = 1'b0;
    sel_nx = '0;
    fd_nx  = (state_nx != IDLE) && (idx_nx == LAST_IDX) && (cnt_nx == LAST_CNT);
    if (state_nx == LIT) begin
      sel_nx          = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_nx;
      {seg_nx, dp_nx} = active[{idx_nx, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg        <= '0;
      dp         <= 1'b0;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_nx;
      dp         <= dp_nx;
      digit_sel  <= sel_nx;
      frame_done <= fd_nx;
    end
  end

  // Pending/active buffers. Swap requires pending already set, so a transfer
  // landing on the frame-end edge waits for the following frame end.
  assign xfer       = load_valid && !pending;
  assign swap       = pending && (frame_done || state == IDLE);
  assign load_ready = ~pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active   <= '0;
      pend_buf <= '0;
      pending  <= 1'b0;
    end else if (swap) begin
      active  <= pend_buf;
      pending <= 1'b0;
    end else if (xfer) begin
      pend_buf <= load_digits;
      pending  <= 1'b1;
    end
  end

endmodule
